// File: rtl/demux2_pkg.sv
// Shared defaults and channel-index type for the two-way stream demultiplexer.
package demux2_pkg;
  localparam int N_DEF  = 32;
  localparam int CW_DEF = 8;

  typedef logic chan_t;
endpackage

// File: rtl/demux2_stream_reg.sv
// One-entry valid/ready holding register with a delivered-word counter; 1-cycle latency,
// accepts a new word while full only if the current one drains in the same cycle.
module stream_reg #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  input  logic          i_vld,
  input  logic [N-1:0]  i_dat,
  output logic          o_rdy,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [N-1:0]  o_dat,
  output logic [CW-1:0] o_cnt
);
  logic          r_full;
  logic [N-1:0]  r_dat;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_rdy  = !r_full || i_rdy;
  assign w_pop  = r_full && i_rdy;
  assign w_push = i_vld && o_rdy;

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      r_full <= 1'b0;
      r_dat  <= '0;
      r_cnt  <= '0;
    end else begin
      // A refill takes priority over the drain so the slot stays full.
      if (w_push) begin
        r_full <= 1'b1;
        r_dat  <= i_dat;
      end else if (w_pop) begin
        r_full <= 1'b0;
      end
      if (w_pop) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_vld = r_full;
  assign o_dat = r_dat;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/demux2_stream.sv
// Routes one input stream to two independent one-entry output channels by IN_SEL; 1-cycle latency,
// IN_READY follows only the selected channel so a stalled channel never blocks the other.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          IN_SEL,
  input  logic [N-1:0]  IN_DATA,
  output logic          OUT0_VALID,
  input  logic          OUT0_READY,
  output logic [N-1:0]  OUT0_DATA,
  output logic          OUT1_VALID,
  input  logic          OUT1_READY,
  output logic [N-1:0]  OUT1_DATA,
  output logic [CW-1:0] COUNT0,
  output logic [CW-1:0] COUNT1
);
  chan_t w_sel;
  logic  w_vld0;
  logic  w_vld1;
  logic  w_rdy0;
  logic  w_rdy1;

  assign w_sel    = IN_SEL;
  assign w_vld0   = IN_VALID && (w_sel == 1'b0);
  assign w_vld1   = IN_VALID && (w_sel == 1'b1);
  assign IN_READY = w_sel ? w_rdy1 : w_rdy0;

  stream_reg #(.N(N), .CW(CW)) u_ch0 (
    .CLOCK  (CLOCK),
    .nRESET (nRESET),
    .i_vld  (w_vld0),
    .i_dat  (IN_DATA),
    .o_rdy  (w_rdy0),
    .o_vld  (OUT0_VALID),
    .i_rdy  (OUT0_READY),
    .o_dat  (OUT0_DATA),
    .o_cnt  (COUNT0)
  );

  stream_reg #(.N(N), .CW(CW)) u_ch1 (
    .CLOCK  (CLOCK),
    .nRESET (nRESET),
    .i_vld  (w_vld1),
    .i_dat  (IN_DATA),
    .o_rdy  (w_rdy1),
    .o_vld  (OUT1_VALID),
    .i_rdy  (OUT1_READY),
    .o_dat  (OUT1_DATA),
    .o_cnt  (COUNT1)
  );
endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed scenarios plus random traffic against a per-channel queue model.
module tb_demux2_stream;
  logic        CLOCK;
  logic        nRESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_SEL;
  logic [31:0] IN_DATA;
  logic        OUT0_VALID;
  logic        OUT0_READY;
  logic [31:0] OUT0_DATA;
  logic        OUT1_VALID;
  logic        OUT1_READY;
  logic [31:0] OUT1_DATA;
  logic [7:0]  COUNT0;
  logic [7:0]  COUNT1;

  int n_chk = 0;
  int n_err = 0;

  // Model: each channel is a queue of accepted-but-undelivered words.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0;
  logic [31:0] last1;
  int          cnt0;
  int          cnt1;

  demux2_stream #(.N(32), .CW(8)) dut (
    .CLOCK      (CLOCK),
    .nRESET     (nRESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_SEL     (IN_SEL),
    .IN_DATA    (IN_DATA),
    .OUT0_VALID (OUT0_VALID),
    .OUT0_READY (OUT0_READY),
    .OUT0_DATA  (OUT0_DATA),
    .OUT1_VALID (OUT1_VALID),
    .OUT1_READY (OUT1_READY),
    .OUT1_DATA  (OUT1_DATA),
    .COUNT0     (COUNT0),
    .COUNT1     (COUNT1)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    cnt0  = 0;
    cnt1  = 0;
  endtask

  task automatic check_outputs();
    chk("out0_valid", OUT0_VALID, q0.size() > 0);
    chk("out1_valid", OUT1_VALID, q1.size() > 0);
    chk("out0_data",  OUT0_DATA,  (q0.size() > 0) ? q0[0] : last0);
    chk("out1_data",  OUT1_DATA,  (q1.size() > 0) ? q1[0] : last1);
    chk("count0",     COUNT0,     cnt0 % 256);
    chk("count1",     COUNT1,     cnt1 % 256);
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides of the next edge.
  task automatic step(input logic v, input logic s, input logic [31:0] d,
                      input logic r0, input logic r1);
    bit exp_rdy;
    bit push;
    bit pop0;
    bit pop1;
    IN_VALID   = v;
    IN_SEL     = s;
    IN_DATA    = d;
    OUT0_READY = r0;
    OUT1_READY = r1;
    #1;
    exp_rdy = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    chk("in_ready", IN_READY, exp_rdy);
    push = v && exp_rdy;
    pop0 = (q0.size() > 0) && r0;
    pop1 = (q1.size() > 0) && r1;
    @(posedge CLOCK);
    #1;
    if (pop0) begin last0 = q0.pop_front(); cnt0++; end
    if (pop1) begin last1 = q1.pop_front(); cnt1++; end
    if (push) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    check_outputs();
  endtask

  // Asynchronous reset pulse placed mid-cycle, held across one rising edge.
  task automatic pulse_reset();
    #2;
    nRESET = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge CLOCK);
    #1;
    check_outputs();
    #3;
    nRESET = 1'b1;
    @(posedge CLOCK);
    #1;
    check_outputs();
  endtask

  initial begin
    nRESET     = 1'b0;
    IN_VALID   = 1'b0;
    IN_SEL     = 1'b0;
    IN_DATA    = '0;
    OUT0_READY = 1'b0;
    OUT1_READY = 1'b0;
    model_clear();
    #2;
    check_outputs();
    @(posedge CLOCK);
    #3;
    nRESET = 1'b1;
    @(posedge CLOCK);
    #1;
    IN_SEL = 1'b0;
    #1;
    chk("rdy_after_reset_sel0", IN_READY, 1'b1);
    IN_SEL = 1'b1;
    #1;
    chk("rdy_after_reset_sel1", IN_READY, 1'b1);
    @(posedge CLOCK);
    #1;

    // Single word to channel 0, delivered and counted.
    step(1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0);
    chk("ch0_first_data", OUT0_DATA, 32'h80000000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("ch0_first_count", COUNT0, 8'd1);
    chk("ch1_idle", OUT1_VALID, 1'b0);

    // Channel 1 stalls: second word waits, then drains and refills together.
    step(1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    chk("ch1_stall_hold", OUT1_DATA, 32'h00000001);
    step(1'b1, 1'b1, 32'h00000002, 1'b1, 1'b1);
    chk("ch1_refill_data", OUT1_DATA, 32'h00000002);

    // Channel 1 still full and stalled; channel 0 keeps flowing.
    step(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
    chk("ch0_bypass_stall", OUT0_DATA, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Back-to-back stream: counter wraps past 255.
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("count0_wrap", COUNT0, 8'd44);

    // Random traffic with occasional sink stalls on either channel.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Held word is discarded by reset and never appears.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ch0_held_deadbeef", OUT0_DATA, 32'hDEADBEEF);
    IN_VALID   = 1'b0;
    OUT0_READY = 1'b1;
    pulse_reset();
    chk("reset_count0", COUNT0, 8'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("reset_no_delivery", OUT0_VALID, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter: N, 32, data width in bits.
REQ-002 Parameter: CW, 8, width of per-channel transfer counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 CLOCK  input  1  rising-edge clock for all state.
REQ-005 nRESET  input  1  asynchronous active-low reset.
REQ-006 IN_VALID  input  1  source has a word on IN_DATA/IN_SEL.
REQ-007 IN_READY  output  1  block accepts the word this cycle.
REQ-008 IN_SEL  input  1  destination channel: 0 -> channel 0, 1 -> channel 1.
REQ-009 IN_DATA  input  N  word to route.
REQ-010 OUT0_VALID, OUT1_VALID  output  1 each  channel holds a valid word.
REQ-011 OUT0_READY, OUT1_READY  input  1 each  sink takes the word this cycle.
REQ-012 OUT0_DATA, OUT1_DATA  output  N each  held word per channel.
REQ-013 COUNT0, COUNT1  output  CW each  words delivered per channel, i.e. output handshakes completed.

Function
REQ-014 Input transfer occurs when IN_VALID && IN_READY are both high at a rising CLOCK edge.
REQ-015 Output transfer on channel k occurs when OUTk_VALID && OUTk_READY are both high at a rising CLOCK edge.
REQ-016 Each channel has a one-entry holding register with state EMPTY (OUTk_VALID=0) or FULL (OUTk_VALID=1).
REQ-017 IN_READY is combinational: high when the channel selected by IN_SEL is EMPTY, or when it is FULL with OUTk_READY high (drain and refill in the same cycle).
REQ-018 IN_READY does not depend on IN_VALID or on the non-selected channel.
REQ-019 Latency: a word accepted at edge t appears on OUTk_DATA with OUTk_VALID=1 after edge t, i.e. one cycle.
REQ-020 Channel transitions:
  - EMPTY -> FULL on an input transfer to channel k.
  - FULL -> EMPTY on an output transfer with no input transfer to channel k.
  - FULL -> FULL with the new data on a simultaneous output and input transfer.
  - Otherwise the state holds.
REQ-021 While FULL and not drained, OUTk_DATA and OUTk_VALID stay stable; no word is ever overwritten without being delivered.
REQ-022 Channels are independent: a stalled channel (OUTk_READY=0) never blocks words destined to the other channel.
REQ-023 Per-channel order is preserved; no ordering guarantee exists across channels.
REQ-024 COUNTk increments by 1 on each output transfer on channel k, and wraps from 2^CW-1 to 0 with no flag.
REQ-025 IN_DATA and IN_SEL are don't-care when IN_VALID=0; IN_SEL shall be known (not X) whenever IN_VALID=1.
REQ-026 OUTk_DATA retains its last delivered value after the channel goes EMPTY; sinks ignore it when OUTk_VALID=0.

Reset
REQ-027 Asserting nRESET=0 immediately forces OUT0_VALID=OUT1_VALID=0, OUT0_DATA=OUT1_DATA=0 and COUNT0=COUNT1=0, with no clock required.
REQ-028 Reset during operation discards any held words; no transfer is counted at a reset edge.
REQ-029 After reset deassertion, IN_READY=1 for either IN_SEL value, since both channels are EMPTY.

Structure
REQ-030 A shared package demux2_pkg holds the default N=32, the default CW=8 and the channel-index typedef (1 bit).
REQ-031 A single sub-module stream_reg (one-entry valid/ready holding register plus its CW counter) is instantiated twice.
REQ-032 demux2_stream contains only select decode, IN_READY logic and the two instances.

Verification
REQ-033 Reset, then IN_VALID=1, IN_SEL=0, IN_DATA=32'h80000000, OUT0_READY=1 -> next cycle OUT0_VALID=1, OUT0_DATA=32'h80000000; COUNT0=1 after the following edge; OUT1_VALID stays 0.
REQ-034 OUT1_READY=0; send 32'h00000001 then 32'h00000002 to channel 1 -> the first is held, IN_READY=0 while IN_SEL=1; after OUT1_READY=1 for one cycle, OUT1_DATA=32'h00000002.
REQ-035 Channel 1 FULL and stalled; send 32'hA5A5A5A5 to channel 0 -> accepted (IN_READY=1) and delivered on OUT0 one cycle later.
REQ-036 Both channels ready; stream 300 back-to-back words to channel 0 -> IN_READY stays 1 every cycle and COUNT0 ends at 44 (300 mod 256).
REQ-037 Channel 0 FULL with 32'hDEADBEEF; pulse nRESET low mid-cycle -> OUT0_VALID=0 and COUNT0=0 immediately; the word is never delivered.
